// File: rtl/nbit_cpu_pkg.sv
// Shared constants for the nbit_cpu: default sizes, opcode field width and opcode encodings.
package nbit_cpu_pkg;

   localparam int unsigned DW_DEFAULT          = 4;
   localparam int unsigned STACK_DEPTH_DEFAULT = 4;
   localparam int unsigned OP_W                = 4;

   localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
   localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;
   localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
   localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;
   localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;
   localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
   localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
   localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;
   localparam logic [OP_W-1:0] OP_NOP    = 4'b1000;
   localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
   localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
   localparam logic [OP_W-1:0] OP_CALL   = 4'b1100;
   localparam logic [OP_W-1:0] OP_RET    = 4'b1101;
   localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
   localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

endpackage

// File: rtl/nbit_cpu_if.sv
// Instruction/IO bundle of the nbit_cpu; master is the program source, slave is the core.
interface nbit_cpu_if
   import nbit_cpu_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT
);
   logic                 order_valid;
   logic [DW+OP_W-1:0]   order;
   logic [DW-1:0]        IN;
   logic [DW-1:0]        OUT;
   logic [DW-1:0]        CNT;
   logic                 C;
   logic                 stack_err;

   modport master (output order_valid, order, IN, input OUT, CNT, C, stack_err);
   modport slave  (input order_valid, order, IN, output OUT, CNT, C, stack_err);
endinterface

// File: rtl/nbit_cpu_rstack.sv
// LIFO return-address stack; push on full and pop on empty are ignored, the caller flags the error.
module nbit_cpu_rstack #(
   parameter int unsigned DW    = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data_c,
   output logic          o_full_c,
   output logic          o_empty_c
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned SPW = AW + 1;

   logic [DW-1:0]  r_mem [DEPTH];
   logic [SPW-1:0] r_sp;
   logic [AW-1:0]  w_top_idx;

   assign w_top_idx = r_sp[AW-1:0] - AW'(1);
   assign o_data_c  = r_mem[w_top_idx];
   assign o_full_c  = (r_sp == SPW'(DEPTH));
   assign o_empty_c = (r_sp == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sp <= '0;
      end else if (i_push && !o_full_c) begin
         r_mem[r_sp[AW-1:0]] <= i_data;
         r_sp                <= r_sp + SPW'(1);
      end else if (i_pop && !o_empty_c) begin
         r_sp <= r_sp - SPW'(1);
      end
   end
endmodule

// File: rtl/nbit_cpu.sv
// Single-cycle accumulator CPU with A/B registers, carry, PC and output port.
// Define NBIT_CPU_STACK_EN to enable CALL/RET with a return stack.
module nbit_cpu
   import nbit_cpu_pkg::*;
#(
   parameter int unsigned DW          = DW_DEFAULT,
   parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST,
   nbit_cpu_if.slave  bus
);
   if ((DW < 4) || (DW > 16)) begin : g_bad_dw
      $error("nbit_cpu: DW must be in 4..16");
   end
   if ((STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("nbit_cpu: STACK_DEPTH must be a power of two >= 2");
   end

   logic [DW-1:0]   r_a, r_b, r_pc, r_out;
   logic            r_c;
   logic [DW-1:0]   w_nxt_a, w_nxt_b, w_nxt_pc, w_nxt_out;
   logic            w_nxt_c;
   logic [OP_W-1:0] w_op;
   logic [DW-1:0]   w_im, w_pc_inc;
   logic [DW:0]     w_sum_a, w_sum_b;

   assign w_op     = bus.order[DW+OP_W-1:DW];
   assign w_im     = bus.order[DW-1:0];
   assign w_pc_inc = r_pc + DW'(1);
   assign w_sum_a  = {1'b0, r_a} + {1'b0, w_im};
   assign w_sum_b  = {1'b0, r_b} + {1'b0, w_im};

`ifdef NBIT_CPU_STACK_EN
   logic          w_push, w_pop, w_full, w_empty, w_err_set, r_err;
   logic [DW-1:0] w_top;

   nbit_cpu_rstack #(.DW(DW), .DEPTH(STACK_DEPTH)) u_rstack (
      .CLK       (CLK),
      .RST       (RST),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_data    (w_pc_inc),
      .o_data_c  (w_top),
      .o_full_c  (w_full),
      .o_empty_c (w_empty)
   );

   always_ff @(posedge CLK) begin
      if (RST)                              r_err <= 1'b0;
      else if (bus.order_valid && w_err_set) r_err <= 1'b1;
   end
   assign bus.stack_err = r_err;
`else
   assign bus.stack_err = 1'b0;
`endif

   // Decode/ALU; any executed instruction other than ADD leaves C cleared.
   always_comb begin
      w_nxt_a   = r_a;
      w_nxt_b   = r_b;
      w_nxt_c   = 1'b0;
      w_nxt_pc  = w_pc_inc;
      w_nxt_out = r_out;
`ifdef NBIT_CPU_STACK_EN
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_set = 1'b0;
`endif
      case (w_op)
         OP_ADD_A:  {w_nxt_c, w_nxt_a} = w_sum_a;
         OP_MOV_AB: w_nxt_a = r_b;
         OP_IN_A:   w_nxt_a = bus.IN;
         OP_MOV_AI: w_nxt_a = w_im;
         OP_MOV_BA: w_nxt_b = r_a;
         OP_ADD_B:  {w_nxt_c, w_nxt_b} = w_sum_b;
         OP_IN_B:   w_nxt_b = bus.IN;
         OP_MOV_BI: w_nxt_b = w_im;
         OP_OUT_B:  w_nxt_out = r_b;
         OP_OUT_I:  w_nxt_out = w_im;
         OP_JNC:    if (!r_c) w_nxt_pc = w_im;
         OP_JMP:    w_nxt_pc = w_im;
`ifdef NBIT_CPU_STACK_EN
         OP_CALL: begin
            w_nxt_pc  = w_im;
            w_push    = bus.order_valid && !w_full;
            w_err_set = w_full;
         end
         OP_RET: begin
            if (w_empty) begin
               w_err_set = 1'b1;
            end else begin
               w_nxt_pc = w_top;
               w_pop    = bus.order_valid;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= 1'b0;
         r_pc  <= '0;
         r_out <= '0;
      end else if (bus.order_valid) begin
         r_a   <= w_nxt_a;
         r_b   <= w_nxt_b;
         r_c   <= w_nxt_c;
         r_pc  <= w_nxt_pc;
         r_out <= w_nxt_out;
      end
   end

   assign bus.OUT = r_out;
   assign bus.CNT = r_pc;
   assign bus.C   = r_c;
endmodule

// File: doc/nbit_cpu.md
NBIT_CPU -- requirements
Module: nbit_cpu

Interface
REQ-001 Parameter DW, default 4: data, immediate and program-counter width, legal range 4..16.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entries, power of two ≥ 2; used only with STACK_EN.
REQ-003 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 order_valid  input  1  the instruction on `order` is valid this cycle.
REQ-006 order  input  DW+4  instruction: [DW+3:DW] opcode, [DW-1:0] immediate Im.
REQ-007 IN  input  DW  external input port.
REQ-008 OUT  output  DW  registered output port.
REQ-009 CNT  output  DW  program counter, the fetch address of the next instruction.
REQ-010 C  output  1  registered carry flag.
REQ-011 stack_err  output  1  sticky return-stack error flag.

Function
REQ-012 Internal state SHALL be registers A and B (DW bits each), C, PC (drives CNT) and OUT.
REQ-013 With order_valid=1, one instruction SHALL execute per cycle, and every result SHALL be visible on the outputs after that same edge.
REQ-014 With order_valid=0, all state SHALL hold (stall); there is no backpressure output.
REQ-015 Opcodes:
- 0000 ADD A,Im
- 0001 MOV A,B
- 0010 IN A
- 0011 MOV A,Im
- 0100 MOV B,A
- 0101 ADD B,Im
- 0110 IN B
- 0111 MOV B,Im
- 1001 OUT B
- 1011 OUT Im
- 1110 JNC Im
- 1111 JMP Im
- 1100 CALL Im, 1101 RET: STACK_EN only, see REQ-024.
- All others: NOP.
REQ-016 ADD SHALL compute a (DW+1)-bit sum: the low DW bits go to the destination and bit DW goes to C.
REQ-017 Every executed non-ADD instruction, including NOP and jumps, SHALL clear C.
REQ-018 JMP SHALL load PC with Im.
REQ-019 JNC SHALL load PC with Im when C=0 before the edge; otherwise it SHALL set PC to PC+1.
REQ-020 All other executed instructions SHALL set PC to PC+1, wrapping modulo 2^DW (2^DW−1 → 0).
REQ-021 IN A and IN B SHALL sample IN at the executing edge; OUT SHALL change only on OUT B and OUT Im.

Reset
REQ-022 RST=1 at an edge SHALL clear A, B, C, PC, OUT, the stack pointer and stack_err, regardless of order_valid.
REQ-023 Reset asserted mid-program SHALL take priority and discard the instruction presented in that cycle.

Configuration
REQ-024 Macro NBIT_CPU_STACK_EN defined: CALL and RET are enabled with a STACK_DEPTH return stack.
- CALL pushes PC+1 and loads PC with Im.
- RET pops into PC.
- Both clear C.
REQ-025 CALL on a full stack SHALL still jump, SHALL NOT push, and SHALL set stack_err.
REQ-026 RET on an empty stack SHALL set PC to PC+1 and SHALL set stack_err.
REQ-027 stack_err SHALL stay set until reset.
REQ-028 Macro NBIT_CPU_STACK_EN undefined: 1100 and 1101 SHALL be NOP, no stack storage SHALL exist, and stack_err SHALL be constant 0.

Structure
REQ-029 Shared package nbit_cpu_pkg SHALL hold:
- the opcode constants;
- the DW and STACK_DEPTH defaults;
- the opcode field width, 4.
REQ-030 The return stack SHALL be sub-module nbit_cpu_rstack (push, pop, full, empty, data), instantiated only under NBIT_CPU_STACK_EN.
REQ-031 The ALU and decode SHALL be inline in nbit_cpu.

Verification (DW=4)
REQ-032 Reset, then order_valid=1 with order=8'b1011_0001 for 3 cycles -> OUT=1 and CNT=1,2,3 at successive edges.
REQ-033 MOV A,15; ADD A,1 -> C=1 and A=0.
- Then JNC 9 -> CNT=3 (not taken) and C=0.
- Then MOV B,A; OUT B -> OUT=0.
REQ-034 IN=4'b1010; IN B; OUT B -> OUT=4'b1010; JMP 15 then NOP -> CNT=15, then CNT=0 (wrap).
REQ-035 order_valid=0 for 3 cycles mid-program -> CNT, OUT and C unchanged; RST=1 during a valid JMP 7 -> CNT=0 and OUT=0.
REQ-036 STACK_EN:
- CALL 8 at PC=2 -> CNT=8; RET -> CNT=3.
- RET on empty -> CNT=4 and stack_err=1.
- Five nested CALLs -> the fifth jumps and stack_err=1.
